// File: rtl/lif_neuron_stdp.sv
// Leaky integrate-and-fire neuron with saturating membrane, refractory period and per-synapse weights.
// Optional pair-based STDP learning is compiled in when LIF_STDP_EN is defined.
module lif_neuron_stdp #(
  parameter int unsigned N_IN       = 8,
  parameter int unsigned W_BITS     = 8,
  parameter int unsigned P_BITS     = 12,
  parameter int unsigned LEAK_SHIFT = 2,
  parameter int unsigned REFRAC     = 3,
  parameter int unsigned TRACE_LEN  = 4,
  parameter int unsigned W_INIT     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN-1:0]           inputs,
  input  logic                      learn,
  input  logic [P_BITS-1:0]         threshold,
  input  logic                      w_load,
  input  logic [$clog2(N_IN)-1:0]   w_sel,
  input  logic [W_BITS-1:0]         w_data,
  output logic [W_BITS-1:0]         w_rdata,
  output logic                      spike_out,
  output logic [P_BITS-1:0]         potential
);

  localparam int unsigned SEL_W = $clog2(N_IN);
  localparam int unsigned SUM_W = W_BITS + SEL_W;
  localparam int unsigned EXT_N = 1 << SEL_W;
  localparam int unsigned CNT_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam bit          HAS_REFRAC = (REFRAC > 0);

  localparam logic [W_BITS-1:0] W_ONE   = W_BITS'(1);
  localparam logic [W_BITS-1:0] W_MAX   = {W_BITS{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {ST_INTEGRATE, ST_REFRACTORY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fire;
  logic [P_BITS-1:0]   pot_d;
  logic                spike_d;
  logic [SUM_W-1:0]    syn_sum;
  logic [P_BITS-1:0]   leak;
  logic [P_BITS:0]     v_sum;
  logic [P_BITS-1:0]   v_next;
  logic [W_BITS-1:0]   weight_q [N_IN];
  logic [W_BITS-1:0]   weight_d [N_IN];
  logic [W_BITS-1:0]   weight_ext [EXT_N];

  // Weighted sum of active synapses; width holds N_IN full-scale weights.
  always_comb begin
    syn_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (inputs[i]) syn_sum = syn_sum + SUM_W'(weight_q[i]);
    end
  end

  if (LEAK_SHIFT == 0) begin : g_no_leak
    assign leak = '0;
  end else begin : g_leak
    assign leak = potential >> LEAK_SHIFT;
  end

  assign v_sum  = (P_BITS+1)'(potential - leak) + (P_BITS+1)'(syn_sum);
  assign v_next = v_sum[P_BITS] ? {P_BITS{1'b1}} : v_sum[P_BITS-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INTEGRATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: refractory count loaded on fire, exits on the edge it reaches 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INTEGRATE: begin
        if (fire && HAS_REFRAC) begin
          state_d = ST_REFRACTORY;
          cnt_d   = CNT_W'(REFRAC);
        end
      end
      ST_REFRACTORY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_INTEGRATE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INTEGRATE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: membrane and spike next values
  always_comb begin
    fire    = 1'b0;
    pot_d   = '0;
    spike_d = 1'b0;
    if (state_q == ST_INTEGRATE) begin
      if (v_next >= threshold) begin
        fire    = 1'b1;
        spike_d = 1'b1;
      end else begin
        pot_d = v_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      potential <= '0;
      spike_out <= 1'b0;
    end else begin
      potential <= pot_d;
      spike_out <= spike_d;
    end
  end

`ifdef LIF_STDP_EN
  localparam logic [3:0] TR_LEN = 4'(TRACE_LEN);
  localparam logic [3:0] TR_ONE = 4'(1);

  logic [3:0] pre_trace_q [N_IN];
  logic [3:0] pre_trace_d [N_IN];
  logic [3:0] post_trace_q, post_trace_d;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      pre_trace_d[i] = '0;
      if (inputs[i])                 pre_trace_d[i] = TR_LEN;
      else if (pre_trace_q[i] != '0) pre_trace_d[i] = pre_trace_q[i] - TR_ONE;
    end
    post_trace_d = '0;
    if (fire)                    post_trace_d = TR_LEN;
    else if (post_trace_q != '0) post_trace_d = post_trace_q - TR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) pre_trace_q[i] <= '0;
      post_trace_q <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) pre_trace_q[i] <= pre_trace_d[i];
      post_trace_q <= post_trace_d;
    end
  end
`else
  logic unused_learn;
  assign unused_learn = learn;
`endif

  // Weight next value: learning first, then a load to the same index wins
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      weight_d[i] = weight_q[i];
`ifdef LIF_STDP_EN
      if (learn) begin
        if (fire) begin
          if ((inputs[i] || (pre_trace_q[i] != '0)) && (weight_q[i] != W_MAX))
            weight_d[i] = weight_q[i] + W_ONE;
        end else if (inputs[i] && (post_trace_q != '0) && (weight_q[i] != '0)) begin
          weight_d[i] = weight_q[i] - W_ONE;
        end
      end
`endif
      if (w_load && (w_sel == SEL_W'(i))) weight_d[i] = w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) weight_q[i] <= W_BITS'(W_INIT);
    end else begin
      for (int i = 0; i < N_IN; i++) weight_q[i] <= weight_d[i];
    end
  end

  // Read port padded to a power of two so out-of-range selects return 0
  for (genvar j = 0; j < EXT_N; j++) begin : g_ext
    if (j < N_IN) begin : g_real
      assign weight_ext[j] = weight_q[j];
    end else begin : g_pad
      assign weight_ext[j] = '0;
    end
  end

  assign w_rdata = weight_ext[w_sel];

endmodule

// File: tb/tb_lif_neuron_stdp.sv
// Scoreboard bench for lif_neuron_stdp: directed scenarios plus random traffic against a behavioural model.
module tb_lif_neuron_stdp;

  localparam int N_IN = 8, W_BITS = 8, P_BITS = 12, LEAK_SHIFT = 2;
  localparam int REFRAC = 3, TRACE_LEN = 4, W_INIT = 16;
  localparam int SEL_W = 3, P_MAX = 4095, W_MAX = 255;

  logic              clk;
  logic              reset;
  logic [N_IN-1:0]   inputs;
  logic              learn;
  logic [P_BITS-1:0] threshold;
  logic              w_load;
  logic [SEL_W-1:0]  w_sel;
  logic [W_BITS-1:0] w_data;
  logic [W_BITS-1:0] w_rdata;
  logic              spike_out;
  logic [P_BITS-1:0] potential;

  lif_neuron_stdp #(
    .N_IN(N_IN), .W_BITS(W_BITS), .P_BITS(P_BITS), .LEAK_SHIFT(LEAK_SHIFT),
    .REFRAC(REFRAC), .TRACE_LEN(TRACE_LEN), .W_INIT(W_INIT)
  ) dut (
    .clk(clk), .reset(reset), .inputs(inputs), .learn(learn), .threshold(threshold),
    .w_load(w_load), .w_sel(w_sel), .w_data(w_data), .w_rdata(w_rdata),
    .spike_out(spike_out), .potential(potential)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; int val; } rd_exp_t;
  typedef struct { int due; int pot; int spk; } st_exp_t;

  rd_exp_t rd_q[$];
  st_exp_t st_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural neuron: refractory tracked as cycles still to sit out
  int m_v, m_spk, m_refr, m_post;
  int m_w[N_IN];
  int m_pre[N_IN];
  bit m_valid = 1'b0;

  task automatic step(input logic [N_IN-1:0] in, input int thr, input bit lrn,
                      input bit ld, input int sel, input int data, input bit rst);
    int sum, leak_v, nv;
    bit fire;
    rd_exp_t re;
    st_exp_t se;
    @(posedge clk);
    #1;
    inputs = in; threshold = P_BITS'(thr); learn = lrn;
    w_load = ld; w_sel = SEL_W'(sel); w_data = W_BITS'(data); reset = rst;
    if (m_valid) begin
      re.due = cyc;
      re.val = (sel < N_IN) ? m_w[sel] : 0;
      rd_q.push_back(re);
    end
    if (rst) begin
      m_v = 0; m_spk = 0; m_refr = 0; m_post = 0;
      for (int i = 0; i < N_IN; i++) begin m_w[i] = W_INIT; m_pre[i] = 0; end
    end else begin
      fire = 1'b0;
      if (m_refr == 0) begin
        sum = 0;
        for (int i = 0; i < N_IN; i++) if (in[i]) sum += m_w[i];
        leak_v = (LEAK_SHIFT == 0) ? 0 : (m_v >> LEAK_SHIFT);
        nv = m_v - leak_v + sum;
        if (nv > P_MAX) nv = P_MAX;
        if (nv >= thr) begin
          fire = 1'b1; m_v = 0; m_spk = 1; m_refr = REFRAC;
        end else begin
          m_v = nv; m_spk = 0;
        end
      end else begin
        m_refr--; m_v = 0; m_spk = 0;
      end
`ifdef LIF_STDP_EN
      for (int i = 0; i < N_IN; i++) begin
        if (lrn) begin
          if (fire && (in[i] || m_pre[i] > 0)) m_w[i] = (m_w[i] < W_MAX) ? m_w[i] + 1 : W_MAX;
          else if (!fire && in[i] && m_post > 0) m_w[i] = (m_w[i] > 0) ? m_w[i] - 1 : 0;
        end
        m_pre[i] = in[i] ? TRACE_LEN : ((m_pre[i] > 0) ? m_pre[i] - 1 : 0);
      end
      m_post = fire ? TRACE_LEN : ((m_post > 0) ? m_post - 1 : 0);
`endif
      if (ld && sel < N_IN) m_w[sel] = data;
    end
    se.due = cyc + 1; se.pot = m_v; se.spk = m_spk;
    st_q.push_back(se);
    m_valid = 1'b1;
  endtask

  // Monitor: checks every expectation that falls due in the current cycle
  always @(negedge clk) begin
    rd_exp_t re;
    st_exp_t se;
    while (rd_q.size() != 0 && rd_q[0].due == cyc) begin
      re = rd_q.pop_front();
      total++;
      if (w_rdata !== W_BITS'(re.val)) begin
        bad++;
        $display("FAIL w_rdata cyc=%0d sel=%0d got=%0d want=%0d", cyc, w_sel, w_rdata, re.val);
      end
    end
    while (st_q.size() != 0 && st_q[0].due == cyc) begin
      se = st_q.pop_front();
      total++;
      if (potential !== P_BITS'(se.pot)) begin
        bad++;
        $display("FAIL potential cyc=%0d got=%0d want=%0d", cyc, potential, se.pot);
      end
      total++;
      if (spike_out !== 1'(se.spk)) begin
        bad++;
        $display("FAIL spike_out cyc=%0d got=%0d want=%0d", cyc, spike_out, se.spk);
      end
    end
  end

  task automatic sweep_reads();
    for (int s = 0; s < N_IN; s++) step('0, P_MAX, 1'b0, 1'b0, s, 0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, thr;
    reset = 1'b1; inputs = '0; learn = 1'b0; threshold = '0;
    w_load = 1'b0; w_sel = '0; w_data = '0;

    // Reset with all inputs active, then read every weight
    step('1, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    step('1, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    sweep_reads();

    // Leak decay from a single synapse event
    step('0, P_MAX, 1'b0, 1'b0, 0, 0, 1'b1);
    step(8'h01, P_MAX, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 5; k++) step('0, P_MAX, 1'b0, 1'b0, 0, 0, 1'b0);

    // Fire followed by refractory with inputs held
    step('0, 40, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 6; k++) step('1, 40, 1'b0, 1'b0, 0, 0, 1'b0);
    step('0, 40, 1'b0, 1'b0, 0, 0, 1'b0);

    // Saturation with full-scale weights
    step('0, P_MAX, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int s = 0; s < N_IN; s++) step('0, P_MAX, 1'b0, 1'b1, s, W_MAX, 1'b0);
    for (int k = 0; k < 5; k++) step('1, P_MAX, 1'b0, 1'b0, 0, 0, 1'b0);

    // Threshold zero fires on every integrate cycle
    step('0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 9; k++) step('0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    // LTP then LTD in the first refractory cycle
    step('0, 20, 1'b1, 1'b0, 0, 0, 1'b1);
    step(8'h02, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    step(8'h00, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    step(8'h01, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    step(8'h04, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    sweep_reads();

    // Same, with a load to the LTD index taking priority
    step('0, 20, 1'b1, 1'b0, 0, 0, 1'b1);
    step(8'h02, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    step(8'h00, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    step(8'h01, 20, 1'b1, 1'b0, 0, 0, 1'b0);
    step(8'h04, 20, 1'b1, 1'b1, 2, 100, 1'b0);
    sweep_reads();

    // Load during reset is discarded
    step('0, P_MAX, 1'b0, 1'b1, 5, 200, 1'b1);
    step('0, P_MAX, 1'b0, 1'b0, 5, 0, 1'b0);

    // Random traffic
    for (int k = 0; k < 700; k++) begin
      r = $urandom_range(0, 9);
      thr = (r == 0) ? 0 : (r == 9) ? P_MAX : $urandom_range(10, 300);
      r = $urandom_range(0, 3);
      step(N_IN'($urandom & $urandom), thr, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), $urandom_range(0, N_IN - 1),
           (r == 0) ? 0 : (r == 1) ? W_MAX : $urandom_range(0, W_MAX),
           ($urandom_range(0, 99) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rd_q.size() + st_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", rd_q.size() + st_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
